// File: rtl/vdma_axi4_to_axi4s_core.sv
// vdma_axi4_to_axi4s_core: fetches a 2-D frame over AXI4 AR/R and emits it as an AXI4-Stream video stream.
// Define VDMA_READ_ERROR_CNT_EN to add status_rresp_err, a saturating count of non-OKAY R beats.
module vdma_axi4_to_axi4s_core #(
  parameter int AXI4_ID_WIDTH    = 6,
  parameter int AXI4_ADDR_WIDTH  = 32,
  parameter int AXI4_LEN_WIDTH   = 8,
  parameter int AXI4_QOS_WIDTH   = 4,
  parameter int AXI4_DATA_SIZE   = 2,
  parameter int AXI4_DATA_WIDTH  = 8 << AXI4_DATA_SIZE,
  parameter int AXI4S_USER_WIDTH = 1,
  parameter int AXI4S_DATA_WIDTH = 24,
  parameter int STRIDE_WIDTH     = 14,
  parameter int INDEX_WIDTH      = 8,
  parameter int H_WIDTH          = 12,
  parameter int V_WIDTH          = 12
) (
  input  logic                        aresetn,
  input  logic                        aclk,
`ifdef VDMA_READ_ERROR_CNT_EN
  output logic [15:0]                 status_rresp_err,
`endif
  input  logic                        ctl_enable,
  input  logic                        ctl_update,
  output logic                        ctl_busy,
  output logic [INDEX_WIDTH-1:0]      ctl_index,
  input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
  input  logic [STRIDE_WIDTH-1:0]     param_stride,
  input  logic [H_WIDTH-1:0]          param_width,
  input  logic [V_WIDTH-1:0]          param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]   param_arlen,
  output logic [AXI4_ADDR_WIDTH-1:0]  monitor_addr,
  output logic [STRIDE_WIDTH-1:0]     monitor_stride,
  output logic [H_WIDTH-1:0]          monitor_width,
  output logic [V_WIDTH-1:0]          monitor_height,
  output logic [AXI4_LEN_WIDTH-1:0]   monitor_arlen,
  output logic [AXI4_ID_WIDTH-1:0]    m_axi4_arid,
  output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_araddr,
  output logic [1:0]                  m_axi4_arburst,
  output logic [3:0]                  m_axi4_arcache,
  output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_arlen,
  output logic                        m_axi4_arlock,
  output logic [2:0]                  m_axi4_arprot,
  output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_arqos,
  output logic [3:0]                  m_axi4_arregion,
  output logic [2:0]                  m_axi4_arsize,
  output logic                        m_axi4_arvalid,
  input  logic                        m_axi4_arready,
  input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_rid,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic [AXI4_DATA_WIDTH-1:0]  m_axi4_rdata,
  input  logic                        m_axi4_rlast,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready,
  output logic [AXI4S_USER_WIDTH-1:0] m_axi4s_tuser,
  output logic                        m_axi4s_tlast,
  output logic [AXI4S_DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                        m_axi4s_tvalid,
  input  logic                        m_axi4s_tready
);
  localparam logic [0:0] AR_IDLE = 1'b0, AR_ISSUE = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0, R_RUN = 1'b1;
  localparam logic [H_WIDTH-1:0] H_ONE = 1;
  localparam logic [V_WIDTH-1:0] V_ONE = 1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = 1;
  localparam logic [AXI4_ADDR_WIDTH-1:0] ADDR_ONE = 1;
  logic [0:0] ar_state, r_state;
  logic upd_pend, load, start, ar_hs, r_hs, r_beat, r_first;
  logic [AXI4_ADDR_WIDTH-1:0] nx_addr, line_base, addr_step;
  logic [STRIDE_WIDTH-1:0] nx_stride;
  logic [H_WIDTH-1:0] nx_width, nx_step, ar_step, ar_hcnt, r_hcnt;
  logic [V_WIDTH-1:0] nx_height, ar_vcnt, r_vcnt;
  logic [AXI4_LEN_WIDTH-1:0] nx_arlen;
  always_comb begin
    load      = ctl_update || upd_pend;
    nx_addr   = load ? param_addr : monitor_addr;
    nx_stride = load ? param_stride : monitor_stride;
    nx_width  = load ? param_width : monitor_width;
    nx_height = load ? param_height : monitor_height;
    nx_arlen  = load ? param_arlen : monitor_arlen;
    nx_step   = H_WIDTH'(nx_arlen) + H_ONE;
    ar_step   = H_WIDTH'(monitor_arlen) + H_ONE;
    addr_step = (AXI4_ADDR_WIDTH'(monitor_arlen) + ADDR_ONE) << AXI4_DATA_SIZE;
    start     = (!ctl_busy || (ar_state == AR_IDLE && r_state == R_IDLE)) && ctl_enable;
    ar_hs     = m_axi4_arvalid && m_axi4_arready;
    r_hs      = m_axi4_rvalid && m_axi4_rready;
    r_beat    = r_hs && r_state == R_RUN;
  end
  assign m_axi4_rready   = !m_axi4s_tvalid || m_axi4s_tready;
  assign m_axi4_arid     = '0;
  assign m_axi4_arburst  = 2'b01;
  assign m_axi4_arcache  = 4'b0011;
  assign m_axi4_arlock   = 1'b0;
  assign m_axi4_arprot   = 3'b000;
  assign m_axi4_arqos    = '0;
  assign m_axi4_arregion = 4'b0000;
  assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);
  assign m_axi4_arlen    = monitor_arlen;
  // ctl_update may be a pulse mid-frame, so it is remembered until the next frame start
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ctl_busy  <= 1'b0;
      ctl_index <= '0;
      upd_pend  <= 1'b0;
    end else begin
      upd_pend <= !start && (upd_pend || ctl_update);
      if (start) begin
        ctl_busy  <= 1'b1;
        ctl_index <= ctl_index + IDX_ONE;
      end else if (!ctl_enable && ar_state == AR_IDLE && r_state == R_IDLE) ctl_busy <= 1'b0;
    end
  end
  always_ff @(posedge aclk) begin
    if (start && load) begin
      monitor_addr   <= param_addr;
      monitor_stride <= param_stride;
      monitor_width  <= param_width;
      monitor_height <= param_height;
      monitor_arlen  <= param_arlen;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_state       <= AR_IDLE;
      m_axi4_arvalid <= 1'b0;
    end else if (start) begin
      ar_state       <= AR_ISSUE;
      m_axi4_arvalid <= 1'b1;
      m_axi4_araddr  <= nx_addr;
      line_base      <= nx_addr + AXI4_ADDR_WIDTH'(nx_stride);
      ar_hcnt        <= nx_width - nx_step;
      ar_vcnt        <= nx_height - V_ONE;
    end else if (ar_hs) begin
      if (ar_hcnt == '0) begin
        if (ar_vcnt == '0) begin
          ar_state       <= AR_IDLE;
          m_axi4_arvalid <= 1'b0;
        end
        m_axi4_araddr <= line_base;
        line_base     <= line_base + AXI4_ADDR_WIDTH'(monitor_stride);
        ar_hcnt       <= monitor_width - ar_step;
        ar_vcnt       <= ar_vcnt - V_ONE;
      end else begin
        m_axi4_araddr <= m_axi4_araddr + addr_step;
        ar_hcnt       <= ar_hcnt - ar_step;
      end
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state        <= R_IDLE;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
    end else begin
      if (start) begin
        r_state <= R_RUN;
        r_hcnt  <= nx_width - H_ONE;
        r_vcnt  <= nx_height - V_ONE;
        r_first <= 1'b1;
      end else if (r_beat) begin
        r_first <= 1'b0;
        r_hcnt  <= r_hcnt == '0 ? monitor_width - H_ONE : r_hcnt - H_ONE;
        if (r_hcnt == '0) begin
          r_vcnt <= r_vcnt - V_ONE;
          if (r_vcnt == '0) r_state <= R_IDLE;
        end
      end
      if (r_beat) begin
        m_axi4s_tvalid <= 1'b1;
        m_axi4s_tdata  <= m_axi4_rdata[AXI4S_DATA_WIDTH-1:0];
        m_axi4s_tuser  <= AXI4S_USER_WIDTH'(r_first);
        m_axi4s_tlast  <= r_hcnt == '0;
      end else if (m_axi4s_tready) m_axi4s_tvalid <= 1'b0;
    end
  end
`ifdef VDMA_READ_ERROR_CNT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) status_rresp_err <= '0;
    else if (r_hs && m_axi4_rresp != 2'b00 && status_rresp_err != 16'hFFFF) status_rresp_err <= status_rresp_err + 16'd1;
  end
  logic unused_r;
  assign unused_r = ^{m_axi4_rid, m_axi4_rlast, m_axi4_rdata};
`else
  logic unused_r;
  assign unused_r = ^{m_axi4_rid, m_axi4_rlast, m_axi4_rdata, m_axi4_rresp};
`endif
endmodule

// File: tb/tb_vdma_axi4_to_axi4s_core.sv
// tb_vdma_axi4_to_axi4s_core: random AXI4 slave and stream sink around the VDMA core,
// with expected addresses and pixels derived from the frame geometry.
module tb_vdma_axi4_to_axi4s_core;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic ctl_enable = 1'b0, ctl_update = 1'b0, ctl_busy;
  logic [7:0] ctl_index;
  logic [31:0] param_addr = '0, monitor_addr;
  logic [13:0] param_stride = '0, monitor_stride;
  logic [11:0] param_width = '0, param_height = '0, monitor_width, monitor_height;
  logic [7:0] param_arlen = '0, monitor_arlen;
  logic [5:0] m_axi4_arid, m_axi4_rid = '0;
  logic [31:0] m_axi4_araddr, m_axi4_rdata = '0;
  logic [1:0] m_axi4_arburst, m_axi4_rresp = '0;
  logic [3:0] m_axi4_arcache, m_axi4_arqos, m_axi4_arregion;
  logic [7:0] m_axi4_arlen;
  logic [2:0] m_axi4_arprot, m_axi4_arsize;
  logic m_axi4_arlock, m_axi4_arvalid, m_axi4_arready = 1'b0;
  logic m_axi4_rlast = 1'b0, m_axi4_rvalid = 1'b0, m_axi4_rready;
  logic [0:0] m_axi4s_tuser;
  logic m_axi4s_tlast, m_axi4s_tvalid, m_axi4s_tready = 1'b0;
  logic [23:0] m_axi4s_tdata;
`ifdef VDMA_READ_ERROR_CNT_EN
  logic [15:0] status_rresp_err;
`endif
  vdma_axi4_to_axi4s_core dut (
    .aresetn(aresetn), .aclk(aclk),
`ifdef VDMA_READ_ERROR_CNT_EN
    .status_rresp_err(status_rresp_err),
`endif
    .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_busy(ctl_busy), .ctl_index(ctl_index),
    .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
    .param_height(param_height), .param_arlen(param_arlen),
    .monitor_addr(monitor_addr), .monitor_stride(monitor_stride), .monitor_width(monitor_width),
    .monitor_height(monitor_height), .monitor_arlen(monitor_arlen),
    .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arburst(m_axi4_arburst),
    .m_axi4_arcache(m_axi4_arcache), .m_axi4_arlen(m_axi4_arlen), .m_axi4_arlock(m_axi4_arlock),
    .m_axi4_arprot(m_axi4_arprot), .m_axi4_arqos(m_axi4_arqos), .m_axi4_arregion(m_axi4_arregion),
    .m_axi4_arsize(m_axi4_arsize), .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
    .m_axi4_rid(m_axi4_rid), .m_axi4_rresp(m_axi4_rresp), .m_axi4_rdata(m_axi4_rdata),
    .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast), .m_axi4s_tdata(m_axi4s_tdata),
    .m_axi4s_tvalid(m_axi4s_tvalid), .m_axi4s_tready(m_axi4s_tready)
  );
  int total = 0, bad = 0;
  logic [31:0] salt;
  logic [31:0] obs_ar[$], exp_ar[$], sl_addr_q[$];
  logic [7:0] obs_len[$], sl_len_q[$];
  logic [25:0] obs_px[$], exp_px[$];
  logic [31:0] r_addr;
  int r_left = 0, err_left = 0, viol = 0, busy_drops = 0;
  bit r_acc = 0, rnd = 0, hold = 0, watch_busy = 0;
  logic [25:0] hold_val;
  initial forever #5 aclk = ~aclk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction
  // memory slave plus stream sink; every handshake decided at negedge fires on the next posedge
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        sl_addr_q.delete();
        sl_len_q.delete();
        r_left = 0;
        r_acc = 0;
        hold = 0;
        m_axi4_rvalid = 1'b0;
      end else begin
        if (hold && !(m_axi4s_tvalid && {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} == hold_val)) viol++;
        if (watch_busy && !ctl_busy) busy_drops++;
        if (r_acc) m_axi4_rvalid = 1'b0;
        m_axi4_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi4s_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!m_axi4_rvalid) begin
          if (r_left == 0 && sl_addr_q.size() > 0) begin
            r_addr = sl_addr_q.pop_front();
            r_left = int'(sl_len_q.pop_front()) + 1;
          end
          if (r_left > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            m_axi4_rvalid = 1'b1;
            m_axi4_rdata = mem_word(r_addr);
            m_axi4_rlast = r_left == 1;
            m_axi4_rresp = err_left > 0 ? 2'b10 : 2'b00;
            m_axi4_rid = 6'($urandom);
          end
        end
        #1;
        r_acc = m_axi4_rvalid && m_axi4_rready;
        if (r_acc) begin
          r_left--;
          r_addr += 4;
          if (m_axi4_rresp != 2'b00) err_left--;
        end
        if (m_axi4_arvalid && m_axi4_arready) begin
          sl_addr_q.push_back(m_axi4_araddr);
          sl_len_q.push_back(m_axi4_arlen);
          obs_ar.push_back(m_axi4_araddr);
          obs_len.push_back(m_axi4_arlen);
        end
        if (m_axi4s_tvalid && m_axi4s_tready) obs_px.push_back({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata});
        hold = m_axi4s_tvalid && !m_axi4s_tready;
        hold_val = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
      end
    end
  end
  task automatic build_expect(input logic [31:0] base, input int stride, input int w, input int h, input int len);
    logic [31:0] d;
    for (int v = 0; v < h; v++) begin
      for (int b = 0; b < w / (len + 1); b++) exp_ar.push_back(base + 32'(v * stride + b * (len + 1) * 4));
      for (int x = 0; x < w; x++) begin
        d = mem_word(base + 32'(v * stride + x * 4));
        exp_px.push_back({v == 0 && x == 0, x == w - 1, d[23:0]});
      end
    end
  endtask
  task automatic clear_all();
    obs_ar.delete();
    obs_len.delete();
    obs_px.delete();
    exp_ar.delete();
    exp_px.delete();
    viol = 0;
  endtask
  task automatic set_params(input logic [31:0] base, input int stride, input int w, input int h, input int len);
    param_addr = base;
    param_stride = 14'(stride);
    param_width = 12'(w);
    param_height = 12'(h);
    param_arlen = 8'(len);
  endtask
  task automatic run_one(input logic [31:0] base, input int stride, input int w, input int h, input int len);
    int c = 0;
    clear_all();
    build_expect(base, stride, w, h, len);
    set_params(base, stride, w, h, len);
    ctl_update = 1'b1;
    ctl_enable = 1'b1;
    @(negedge aclk);
    ctl_update = 1'b0;
    ctl_enable = 1'b0;
    while ((ctl_busy || obs_px.size() < exp_px.size()) && c < 5000) begin
      @(negedge aclk);
      c++;
    end
    total++;
    if (c >= 5000) begin bad++; $display("FAIL frame_timeout: beats=%0d required=%0d", obs_px.size(), exp_px.size()); end
    repeat (4) @(negedge aclk);
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    ctl_enable = 1'b0;
    ctl_update = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
  endtask
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    total++; if (ctl_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ctl_busy); end
    total++; if (ctl_index !== 8'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", ctl_index); end
    total++; if (m_axi4_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b want 0", m_axi4_arvalid); end
    total++; if (m_axi4s_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_axi4s_tvalid); end
    total++; if (m_axi4s_tuser !== 1'b0 || m_axi4s_tlast !== 1'b0) begin bad++; $display("FAIL reset_tuser_tlast: got %b%b want 00", m_axi4s_tuser, m_axi4s_tlast); end
    total++; if ({m_axi4_arburst, m_axi4_arcache, m_axi4_arsize} !== {2'b01, 4'b0011, 3'd2}) begin bad++; $display("FAIL ar_constants: burst=%b cache=%b size=%0d want 01 0011 2", m_axi4_arburst, m_axi4_arcache, m_axi4_arsize); end
    total++; if ({m_axi4_arid, m_axi4_arlock, m_axi4_arprot, m_axi4_arqos, m_axi4_arregion} !== '0) begin bad++; $display("FAIL ar_zero_fields: got nonzero want 0"); end
`ifdef VDMA_READ_ERROR_CNT_EN
    total++; if (status_rresp_err !== 16'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", status_rresp_err); end
`endif
    aresetn = 1'b1;
    @(negedge aclk);
  endtask
  task automatic test_basic();
    rnd = 0;
    run_one(32'h1000, 32'h100, 4, 2, 1);
    total++; if (obs_ar.size() != exp_ar.size()) begin bad++; $display("FAIL basic_ar_count: got %0d want %0d", obs_ar.size(), exp_ar.size()); end
    for (int i = 0; i < exp_ar.size() && i < obs_ar.size(); i++) begin
      total++; if (obs_ar[i] !== exp_ar[i] || obs_len[i] !== 8'd1) begin bad++; $display("FAIL basic_ar[%0d]: got addr=%h len=%0d want addr=%h len=1", i, obs_ar[i], obs_len[i], exp_ar[i]); end
    end
    total++; if (obs_px.size() != exp_px.size()) begin bad++; $display("FAIL basic_beat_count: got %0d want %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      total++; if (obs_px[i] !== exp_px[i]) begin bad++; $display("FAIL basic_beat[%0d]: got %h want %h", i, obs_px[i], exp_px[i]); end
    end
    total++; if (ctl_index !== 8'd1) begin bad++; $display("FAIL basic_index: got %0d want 1", ctl_index); end
    total++; if (monitor_addr !== 32'h1000 || monitor_arlen !== 8'd1) begin bad++; $display("FAIL basic_monitor: got %h/%0d want 1000/1", monitor_addr, monitor_arlen); end
  endtask
  task automatic test_single();
    logic [7:0] idx0 = ctl_index;
    rnd = 0;
    run_one(32'h4000, 32'h40, 1, 1, 0);
    total++; if (obs_ar.size() != 1 || obs_ar[0] !== 32'h4000 || obs_len[0] !== 8'd0) begin bad++; $display("FAIL single_ar: count=%0d addr=%h want 1 at 4000 len 0", obs_ar.size(), obs_ar[0]); end
    total++; if (obs_px.size() != 1 || obs_px[0] !== exp_px[0]) begin bad++; $display("FAIL single_beat: count=%0d got %h want %h", obs_px.size(), obs_px[0], exp_px[0]); end
    total++; if (obs_px[0][25:24] !== 2'b11) begin bad++; $display("FAIL single_user_last: got %b want 11", obs_px[0][25:24]); end
    total++; if (ctl_busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", ctl_busy); end
    total++; if (ctl_index !== idx0 + 8'd1) begin bad++; $display("FAIL single_index: got %0d want %0d", ctl_index, idx0 + 8'd1); end
  endtask
  task automatic test_backpressure();
    int lens[3] = '{0, 1, 3};
    int len, w, h, stride;
    logic [31:0] base;
    rnd = 1;
    for (int k = 0; k < 4; k++) begin
      len = k == 0 ? 1 : lens[$urandom_range(0, 2)];
      w = k == 0 ? 4 : (len + 1) * int'($urandom_range(1, 4));
      h = k == 0 ? 2 : int'($urandom_range(1, 3));
      stride = k == 0 ? 32'h100 : 256 * int'($urandom_range(1, 4));
      base = k == 0 ? 32'h1000 : 32'h0001_0000 + 4 * $urandom_range(0, 4095);
      run_one(base, stride, w, h, len);
      total++; if (obs_px.size() != exp_px.size()) begin bad++; $display("FAIL bp_beat_count[%0d]: got %0d want %0d", k, obs_px.size(), exp_px.size()); end
      for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
        total++; if (obs_px[i] !== exp_px[i]) begin bad++; $display("FAIL bp_beat[%0d][%0d]: got %h want %h", k, i, obs_px[i], exp_px[i]); end
      end
      total++; if (obs_ar != exp_ar) begin bad++; $display("FAIL bp_ar_list[%0d]: got %0d ARs want %0d", k, obs_ar.size(), exp_ar.size()); end
      total++; if (viol != 0) begin bad++; $display("FAIL bp_hold_stable[%0d]: got %0d changes want 0", k, viol); end
    end
    rnd = 0;
  endtask
  task automatic test_multi();
    int c = 0;
    rnd = 0;
    do_reset();
    clear_all();
    build_expect(32'h1000, 32'h100, 4, 2, 1);
    build_expect(32'h2000, 32'h100, 4, 2, 1);
    build_expect(32'h2000, 32'h100, 4, 2, 1);
    set_params(32'h1000, 32'h100, 4, 2, 1);
    busy_drops = 0;
    ctl_update = 1'b1;
    ctl_enable = 1'b1;
    @(negedge aclk);
    ctl_update = 1'b0;
    watch_busy = 1;
    while (obs_px.size() < 3 && c < 1000) begin @(negedge aclk); c++; end
    param_addr = 32'h2000;
    ctl_update = 1'b1;
    @(negedge aclk);
    ctl_update = 1'b0;
    c = 0;
    while (ctl_index != 8'd3 && c < 2000) begin @(negedge aclk); c++; end
    ctl_enable = 1'b0;
    watch_busy = 0;
    c = 0;
    while ((ctl_busy || obs_px.size() < exp_px.size()) && c < 2000) begin @(negedge aclk); c++; end
    repeat (4) @(negedge aclk);
    total++; if (c >= 2000) begin bad++; $display("FAIL multi_timeout: beats=%0d want %0d", obs_px.size(), exp_px.size()); end
    total++; if (obs_ar != exp_ar) begin bad++; $display("FAIL multi_ar_list: got %0d ARs first_f2=%h want %0d from 2000", obs_ar.size(), obs_ar[4], exp_ar.size()); end
    total++; if (obs_px.size() != exp_px.size()) begin bad++; $display("FAIL multi_beat_count: got %0d want %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      total++; if (obs_px[i] !== exp_px[i]) begin bad++; $display("FAIL multi_beat[%0d]: got %h want %h", i, obs_px[i], exp_px[i]); end
    end
    total++; if (ctl_index !== 8'd3) begin bad++; $display("FAIL multi_index: got %0d want 3", ctl_index); end
    total++; if (busy_drops != 0) begin bad++; $display("FAIL multi_busy_held: got %0d drops want 0", busy_drops); end
    total++; if (monitor_addr !== 32'h2000) begin bad++; $display("FAIL multi_monitor_addr: got %h want 2000", monitor_addr); end
  endtask
  task automatic test_reset_mid();
    int c = 0;
    rnd = 1;
    clear_all();
    set_params(32'h3000, 32'h100, 8, 4, 1);
    ctl_update = 1'b1;
    ctl_enable = 1'b1;
    @(negedge aclk);
    ctl_update = 1'b0;
    while (obs_px.size() < 3 && c < 2000) begin @(negedge aclk); c++; end
    total++; if (ctl_busy !== 1'b1) begin bad++; $display("FAIL midreset_pre_busy: got %b want 1", ctl_busy); end
    aresetn = 1'b0;
    ctl_enable = 1'b0;
    @(negedge aclk);
    total++; if (m_axi4_arvalid !== 1'b0) begin bad++; $display("FAIL midreset_arvalid: got %b want 0", m_axi4_arvalid); end
    total++; if (m_axi4s_tvalid !== 1'b0) begin bad++; $display("FAIL midreset_tvalid: got %b want 0", m_axi4s_tvalid); end
    total++; if (ctl_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", ctl_busy); end
    total++; if (ctl_index !== 8'd0) begin bad++; $display("FAIL midreset_index: got %0d want 0", ctl_index); end
    @(negedge aclk);
    aresetn = 1'b1;
    rnd = 0;
    repeat (10) @(negedge aclk);
    total++; if (m_axi4s_tvalid !== 1'b0 || m_axi4_arvalid !== 1'b0 || ctl_busy !== 1'b0) begin bad++; $display("FAIL midreset_idle: got tvalid=%b arvalid=%b busy=%b want 000", m_axi4s_tvalid, m_axi4_arvalid, ctl_busy); end
  endtask
  task automatic test_rresp();
    rnd = 0;
    err_left = 3;
    run_one(32'h5000, 32'h100, 4, 2, 1);
    total++; if (obs_px.size() != exp_px.size()) begin bad++; $display("FAIL rresp_beat_count: got %0d want %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      total++; if (obs_px[i] !== exp_px[i]) begin bad++; $display("FAIL rresp_beat[%0d]: got %h want %h", i, obs_px[i], exp_px[i]); end
    end
`ifdef VDMA_READ_ERROR_CNT_EN
    total++; if (status_rresp_err !== 16'd3) begin bad++; $display("FAIL rresp_err_cnt: got %0d want 3", status_rresp_err); end
`endif
  endtask
  initial begin
    salt = $urandom;
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_multi();
    test_reset_mid();
    test_rresp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vdma_axi4_to_axi4s_core.md
Name: vdma_axi4_to_axi4s_core

Overview:
Video DMA read core. Fetches a 2-D frame from memory over an AXI4 read master (AR/R channels) and emits it as an AXI4-Stream video stream: tuser marks the first pixel of a frame, tlast marks the last pixel of each line. It sits between the AXI interconnect and the DVI/VGA timing path. Outstanding-transaction limits are left to the interconnect; this core stays simple.

Parameters:
AXI4_ID_WIDTH, 6, ARID/RID width
AXI4_ADDR_WIDTH, 32, address width
AXI4_LEN_WIDTH, 8, ARLEN width
AXI4_QOS_WIDTH, 4, ARQOS width
AXI4_DATA_SIZE, 2, beat size code (2 = 32 bit)
AXI4_DATA_WIDTH, 8<<AXI4_DATA_SIZE, RDATA width
AXI4S_USER_WIDTH, 1, tuser width
AXI4S_DATA_WIDTH, 24, tdata width (low bits of RDATA)
STRIDE_WIDTH, 14, line stride in bytes
INDEX_WIDTH, 8, frame index counter width
H_WIDTH, 12, width counter (beats)
V_WIDTH, 12, height counter (lines)

Ports:
aresetn  in  1  synchronous reset, active low
aclk  in  1  clock
ctl_enable  in  1  run frames continuously while high
ctl_update  in  1  load param_* at the next frame start
ctl_busy  out  1  frame in progress
ctl_index  out  INDEX_WIDTH  increments at each frame start
param_addr/stride/width/height/arlen  in  ADDR/STRIDE/H/V/LEN widths  frame base, line stride, beats per line, lines, burst length-1
monitor_addr/stride/width/height/arlen  out  same widths  active shadow parameters
m_axi4_arid/araddr/arburst/arcache/arlen/arlock/arprot/arqos/arregion/arsize/arvalid  out  standard  AR channel
m_axi4_arready  in  1  AR accept
m_axi4_rid/rresp/rdata/rlast/rvalid  in  standard  R channel
m_axi4_rready  out  1  R accept
m_axi4s_tuser  out  AXI4S_USER_WIDTH  frame start
m_axi4s_tlast  out  1  line end
m_axi4s_tdata  out  AXI4S_DATA_WIDTH  pixel
m_axi4s_tvalid  out  1  stream valid
m_axi4s_tready  in  1  stream accept

Behaviour:
- Reset: ctl_busy=0, ctl_index=0, arvalid=0, tvalid=0, tuser=0, tlast=0. All other registers are don't-care.
- Constant outputs: arid=0, arburst=INCR(01), arcache=0011, arlock=0, arprot=0, arqos=0, arregion=0, arsize=AXI4_DATA_SIZE, arlen=shadow arlen.
- Frame start happens when (!busy || (!arbusy && !rbusy)) && ctl_enable. On that cycle: busy<=1, index++. If ctl_update is high, the shadows are loaded from param_*. When ctl_enable is low, busy<=0 once idle.
- AR state, IDLE -> ISSUE -> IDLE:
  - At frame start: araddr=param base, line base = base+stride, hcnt=width-(arlen+1), vcnt=height-1.
  - On each arvalid&&arready: araddr += (arlen+1)<<AXI4_DATA_SIZE and hcnt -= arlen+1.
  - When hcnt==0, the line wraps: araddr=line base, line base += stride, vcnt--.
  - When vcnt==0 at line end, arvalid drops and AR returns to IDLE.
  - width must be a multiple of arlen+1; any other width is undefined behaviour.
- R/stream state, IDLE -> RUN -> IDLE:
  - One-deep output register. rready = !tvalid || tready.
  - On rvalid&&rready: tdata=rdata[AXI4S_DATA_WIDTH-1:0], tvalid=1.
  - tuser=1 only on the first beat of the frame.
  - tlast=1 when the beat's hcnt==0 (hcnt reloads to width-1).
  - The last beat of the last line ends RUN.
  - A beat is held stable until tready, and tvalid stays high across beats with no bubble when tready=1.
- One beat per cycle sustained. Latency is 1 cycle from R handshake to tvalid.
- rresp/rid are ignored. rlast is not used for counting; the counters are authoritative.
- Simultaneous end-of-frame and ctl_enable: the next frame starts on the following cycle without deasserting busy.
- Reset mid-frame: outputs return to reset values at the next clock edge. Outstanding AXI responses after reset are the system's responsibility.
- width=1, height=1, arlen=0: a single AR is issued, and one beat goes out with tuser=tlast=1.

Optional Feature:
VDMA_READ_ERROR_CNT_EN:
- Defined: adds output status_rresp_err[15:0]. It counts R beats with rresp!=OKAY, saturates at FFFF, and clears at reset.
- Undefined: the port is absent and rresp is fully ignored.

Test Plan:
- width=4, height=2, arlen=1, stride=0x100, base=0x1000, always-ready -> AR addrs 0x1000, 0x1008, 0x1100, 0x1108; 8 beats; tuser on beat 0; tlast on beats 3 and 7; ctl_index=1.
- Same config with tready toggled 50% random and rvalid random -> tdata order matches memory, no beat lost or duplicated, tdata held stable while tvalid&&!tready.
- ctl_enable held high for 3 frames; ctl_update pulsed with a new base 0x2000 mid-frame 1 -> frame 2 fetches from 0x2000; ctl_index=3; busy never drops.
- width=1, height=1, arlen=0 -> one AR, one beat, tuser=tlast=1, busy clears after the frame.
- aresetn low mid-line -> next cycle arvalid=0, tvalid=0, busy=0, index=0.
- VDMA_READ_ERROR_CNT_EN defined, 3 beats with rresp=SLVERR -> status_rresp_err=3, stream data is unaffected.
